ecc_enc_stream: RTL

- Streaming parameterized extended-Hamming (SECDED) encoder with valid/ready handshakes on both sides and 0–2 pipeline stages.
- Produces the codeword format consumed by the team's SECDED decoder.
- Includes a one-shot error-injection facility for in-system decoder testing, plus a transfer counter.
- Sits on the write path of ECC-protected memories and links.

---
 rtl/ecc_pkg.sv | 59 +++++
 rtl/ecc_enc_stream_if.sv | 30 +++
 rtl/ecc_pipe_stage.sv | 45 ++++
 rtl/ecc_enc_stream.sv | 115 +++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: check-bit sizing and the extended-Hamming encode used by
// both the streaming encoder and the matching decoder.
package ecc_pkg;

    localparam int MAX_K  = 120;
    localparam int MAX_CW = 128;
    localparam int IDX_W  = 7;

    function automatic int calculate_m(input int k);
        int m;
        m = 32'sd1;
        // The condition is monotonic in i, so the last failing i gives the smallest m.
        for (int i = 32'sd1; i <= 32'sd15; i++) begin
            if ((32'sd1 << i) < (i + k + 32'sd1)) m = i + 32'sd1;
        end
        return m;
    endfunction

    function automatic bit is_power_of_2(input int x);
        return (x > 32'sd0) && ((x & (x - 32'sd1)) == 32'sd0);
    endfunction

    function automatic logic [MAX_CW-1:0] hamming_encode(input logic [MAX_K-1:0] d,
                                                          input int k,
                                                          input bit p0_lsb);
        logic [MAX_CW-1:0] pos;
        logic [MAX_CW-1:0] q;
        logic              par;
        logic              p0;
        int                n;
        int                di;
        n   = calculate_m(k) + k;
        pos = '0;
        di  = 32'sd0;
        for (int i = 32'sd1; i < MAX_CW; i++) begin
            if ((i <= n) && !is_power_of_2(i) && (di < MAX_K)) begin
                pos[i[IDX_W-1:0]] = d[di[IDX_W-1:0]];
                di++;
            end
        end
        for (int j = 32'sd0; j < IDX_W; j++) begin
            par = 1'b0;
            for (int i = 32'sd1; i < MAX_CW; i++) begin
                if ((i <= n) && (((i >>> j) & 32'sd1) != 32'sd0)) par = par ^ pos[i[IDX_W-1:0]];
            end
            if ((32'sd1 << j) <= n) pos[IDX_W'(32'sd1 << j)] = par;
        end
        p0 = ^pos;
        if (p0_lsb) begin
            q    = pos;
            q[0] = p0;
        end else begin
            q                 = pos >> 1;
            q[n[IDX_W-1:0]]   = p0;
        end
        return q;
    endfunction

endpackage

// File: rtl/ecc_enc_stream_if.sv
// Stream bundle of the SECDED encoder: data-in handshake, codeword-out handshake,
// error-injection control and the transfer counter.
interface ecc_enc_stream_if #(
    parameter int K     = 8,
    parameter int CNT_W = 16
);
    localparam int CW = ecc_pkg::calculate_m(K) + K + 1;

    logic [K-1:0]     d_i;
    logic             valid_i;
    logic             ready_o;
    logic [CW-1:0]    q_o;
    logic             valid_o;
    logic             ready_i;
    logic             inj_i;
    logic [CW-1:0]    inj_mask_i;
    logic             inj_pending_o;
    logic             inj_o;
    logic [CNT_W-1:0] word_cnt_o;

    modport slave (
        input  d_i, valid_i, ready_i, inj_i, inj_mask_i,
        output ready_o, q_o, valid_o, inj_pending_o, inj_o, word_cnt_o
    );

    modport master (
        output d_i, valid_i, ready_i, inj_i, inj_mask_i,
        input  ready_o, q_o, valid_o, inj_pending_o, inj_o, word_cnt_o
    );
endinterface

// File: rtl/ecc_pipe_stage.sv
// Valid/ready register slice; accepts a new word whenever empty or draining,
// so back-to-back stages sustain one word per cycle.
module ecc_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // next-state: load on accept, otherwise hold (data stays put while stalled)
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) data_d = in_data_i;
            else            data_d = data_q;
        end else begin
            valid_d = valid_q;
        end
    end

    // slice registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/ecc_enc_stream.sv
// Streaming extended-Hamming encoder with 0..2 register stages, one-shot
// codeword corruption for decoder testing, and an output transfer counter.
module ecc_enc_stream
    import ecc_pkg::*;
#(
    parameter int K       = 8,
    parameter int LATENCY = 1,
    parameter int P0_LSB  = 1,
    parameter int CNT_W   = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    ecc_enc_stream_if.slave    bus
);
    localparam int CW = calculate_m(K) + K + 1;

    function automatic logic [CW-1:0] encode_word(input logic [K-1:0] d);
        logic [MAX_K-1:0]  ext;
        logic [MAX_CW-1:0] full;
        ext        = '0;
        ext[K-1:0] = d;
        full       = hamming_encode(ext, K, P0_LSB != 32'sd0);
        return full[CW-1:0];
    endfunction

    logic             inj_pending_q, inj_pending_d;
    logic [CW-1:0]    inj_mask_q, inj_mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_s, in_xfer_s, out_valid_s, out_xfer_s, out_tag_s, inj_hit_s;
    logic [CW-1:0]    eff_mask_s, out_cw_s;

    assign in_xfer_s  = bus.valid_i & in_ready_s;
    assign out_xfer_s = out_valid_s & bus.ready_i;
    assign inj_hit_s  = bus.valid_i & (inj_pending_q | bus.inj_i);

    // injection bookkeeping: same-cycle mask wins; a word transfer consumes the arming
    always_comb begin
        inj_pending_d = inj_pending_q;
        inj_mask_d    = inj_mask_q;
        if (inj_hit_s) eff_mask_s = bus.inj_i ? bus.inj_mask_i : inj_mask_q;
        else           eff_mask_s = '0;
        if (in_xfer_s && (inj_pending_q || bus.inj_i)) begin
            inj_pending_d = 1'b0;
        end else if (bus.inj_i) begin
            inj_pending_d = 1'b1;
            inj_mask_d    = bus.inj_mask_i;
        end else begin
            inj_pending_d = inj_pending_q;
        end
        if (out_xfer_s) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else            cnt_d = cnt_q;
    end

    // control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inj_pending_q <= 1'b0;
            inj_mask_q    <= '0;
            cnt_q         <= '0;
        end else begin
            inj_pending_q <= inj_pending_d;
            inj_mask_q    <= inj_mask_d;
            cnt_q         <= cnt_d;
        end
    end

    generate
        if (LATENCY == 0) begin : g_l0
            assign in_ready_s  = bus.ready_i;
            assign out_valid_s = bus.valid_i & !rst_i;
            assign out_cw_s    = rst_i ? '0 : (encode_word(bus.d_i) ^ eff_mask_s);
            assign out_tag_s   = inj_hit_s & !rst_i;
        end else if (LATENCY == 1) begin : g_l1
            logic [CW:0] s_in, s_out;
            logic        s_valid;
            assign s_in = {inj_hit_s, encode_word(bus.d_i) ^ eff_mask_s};
            ecc_pipe_stage #(.W(CW + 1)) u_stage (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_valid_i(bus.valid_i), .in_ready_o(in_ready_s), .in_data_i(s_in),
                .out_valid_o(s_valid), .out_ready_i(bus.ready_i), .out_data_o(s_out)
            );
            assign out_valid_s = s_valid;
            assign out_cw_s    = s_out[CW-1:0];
            assign out_tag_s   = s_valid & s_out[CW];
        end else begin : g_l2
            // stage A keeps raw data plus the resolved mask; encoding sits between A and B
            localparam int WA = 1 + CW + K;
            logic [WA-1:0] a_in, a_out;
            logic [CW:0]   b_in, b_out;
            logic          a_valid, b_ready, b_valid;
            assign a_in = {inj_hit_s, eff_mask_s, bus.d_i};
            ecc_pipe_stage #(.W(WA)) u_stage_a (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_valid_i(bus.valid_i), .in_ready_o(in_ready_s), .in_data_i(a_in),
                .out_valid_o(a_valid), .out_ready_i(b_ready), .out_data_o(a_out)
            );
            assign b_in = {a_out[WA-1], encode_word(a_out[K-1:0]) ^ a_out[K +: CW]};
            ecc_pipe_stage #(.W(CW + 1)) u_stage_b (
                .clk_i(clk_i), .rst_i(rst_i),
                .in_valid_i(a_valid), .in_ready_o(b_ready), .in_data_i(b_in),
                .out_valid_o(b_valid), .out_ready_i(bus.ready_i), .out_data_o(b_out)
            );
            assign out_valid_s = b_valid;
            assign out_cw_s    = b_out[CW-1:0];
            assign out_tag_s   = b_valid & b_out[CW];
        end
    endgenerate

    assign bus.ready_o       = in_ready_s;
    assign bus.valid_o       = out_valid_s;
    assign bus.q_o           = out_cw_s;
    assign bus.inj_o         = out_tag_s;
    assign bus.inj_pending_o = inj_pending_q;
    assign bus.word_cnt_o    = cnt_q;
endmodule
